// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate scheduler and the display logic.
// Optional build macro: PARK_EXIT_PRIORITY_EN (exit lane wins arbitration ties).
package parking_pkg;

   // Gate controller states
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      OPEN_ENT  = 2'd1,
      OPEN_EXIT = 2'd2,
      GUARD     = 2'd3
   } gate_state_e;

   // Lane select encoding, also used as the round-robin "last served" pointer
   typedef enum logic {
      LANE_ENT  = 1'b0,
      LANE_EXIT = 1'b1
   } lane_e;

   // 7-segment patterns, bit order {g,f,e,d,c,b,a}, active high
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Decimal digit to segment pattern; non-decimal values blank the digit
   function automatic logic [6:0] seg7_digit(input logic [3:0] d);
      case (d)
         4'd0:    seg7_digit = SEG_0;
         4'd1:    seg7_digit = SEG_1;
         4'd2:    seg7_digit = SEG_2;
         4'd3:    seg7_digit = SEG_3;
         4'd4:    seg7_digit = SEG_4;
         4'd5:    seg7_digit = SEG_5;
         4'd6:    seg7_digit = SEG_6;
         4'd7:    seg7_digit = SEG_7;
         4'd8:    seg7_digit = SEG_8;
         4'd9:    seg7_digit = SEG_9;
         default: seg7_digit = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/park_gate_timer.sv
// Gate-open timer: counts open cycles, flags the last allowed cycle.
module park_gate_timer #(
   parameter int OPEN_CYCLES = 50
) (
   input  logic Clk,
   input  logic Rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int TW = (OPEN_CYCLES > 2) ? $clog2(OPEN_CYCLES) : 1;

   logic [TW-1:0] cnt_q, cnt_d;

   // Expire while enabled on the final open cycle (count OPEN_CYCLES-1)
   always_comb expire = enable && (cnt_q == TW'(OPEN_CYCLES - 1));

   // Count up while enabled; restart on clear or once the window has ended
   always_comb begin
      cnt_d = cnt_q;
      if (clear || expire) cnt_d = '0;
      else if (enable)     cnt_d = cnt_q + 1'b1;
   end

   // Counter register
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Shares one barrier gate between entrance and exit lanes, bounds the open
// time and tracks lot occupancy.
// Optional build macro: PARK_EXIT_PRIORITY_EN (exit wins ties; otherwise
// round-robin with entrance winning the first tie after reset).
module parking_gate_scheduler
   import parking_pkg::*;
#(
   parameter  int CAPACITY    = 8,
   parameter  int OPEN_CYCLES = 50,
   localparam int CNT_W       = $clog2(CAPACITY + 1)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             entReq,
   input  logic             exitReq,
   input  logic             entPass,
   input  logic             exitPass,
   output logic             entGrant,
   output logic             exitGrant,
   output logic             gateOpen,
   output logic [CNT_W-1:0] occupancy,
   output logic             full,
   output logic             empty,
   output logic             timeoutErr
);

   gate_state_e      state_q, state_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             ent_grant_q, ent_grant_d;
   logic             exit_grant_q, exit_grant_d;
   logic             tmo_q, tmo_d;

   logic is_open, expire;
   logic ent_hit, exit_hit;
   logic ent_elig, exit_elig;
   logic tie_exit;

   always_comb is_open   = (state_q == OPEN_ENT) || (state_q == OPEN_EXIT);
   always_comb ent_hit   = (state_q == OPEN_ENT)  && entPass;
   always_comb exit_hit  = (state_q == OPEN_EXIT) && exitPass;
   always_comb ent_elig  = entReq  && !full_q;
   always_comb exit_elig = exitReq && !empty_q;

   park_gate_timer #(.OPEN_CYCLES(OPEN_CYCLES)) u_timer (
      .Clk    (Clk),
      .Rst    (Rst),
      .clear  (!is_open),
      .enable (is_open),
      .expire (expire)
   );

`ifdef PARK_EXIT_PRIORITY_EN
   always_comb tie_exit = 1'b1;
`else
   lane_e last_q;

   // Tie goes to the lane served less recently
   always_comb tie_exit = (last_q == LANE_ENT);

   // Record the lane of every grant issued from IDLE
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)                          last_q <= LANE_EXIT;
      else if (state_d == OPEN_ENT  && state_q == IDLE) last_q <= LANE_ENT;
      else if (state_d == OPEN_EXIT && state_q == IDLE) last_q <= LANE_EXIT;
   end
`endif

   // State register
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next state: arbitrate in IDLE, close on pass or expiry, one guard cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (ent_elig && exit_elig) state_d = tie_exit ? OPEN_EXIT : OPEN_ENT;
            else if (ent_elig)         state_d = OPEN_ENT;
            else if (exit_elig)        state_d = OPEN_EXIT;
         end
         OPEN_ENT:  if (entPass  || expire) state_d = GUARD;
         OPEN_EXIT: if (exitPass || expire) state_d = GUARD;
         default:   state_d = IDLE;
      endcase
   end

   // Output next values: grants follow the next state, occupancy follows passes
   always_comb begin
      ent_grant_d  = (state_d == OPEN_ENT);
      exit_grant_d = (state_d == OPEN_EXIT);
      tmo_d        = is_open && expire && !ent_hit && !exit_hit;
      occ_d        = occ_q;
      if (ent_hit)       occ_d = occ_q + 1'b1;
      else if (exit_hit) occ_d = occ_q - 1'b1;
      full_d       = (occ_d == CNT_W'(CAPACITY));
      empty_d      = (occ_d == '0);
   end

   // Output registers
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         ent_grant_q  <= 1'b0;
         exit_grant_q <= 1'b0;
         tmo_q        <= 1'b0;
         occ_q        <= '0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
      end else begin
         ent_grant_q  <= ent_grant_d;
         exit_grant_q <= exit_grant_d;
         tmo_q        <= tmo_d;
         occ_q        <= occ_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
      end
   end

   assign entGrant   = ent_grant_q;
   assign exitGrant  = exit_grant_q;
   assign gateOpen   = ent_grant_q | exit_grant_q;
   assign occupancy  = occ_q;
   assign full       = full_q;
   assign empty      = empty_q;
   assign timeoutErr = tmo_q;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Randomized bench for parking_gate_scheduler with a lane-level reference
// model and an expected-output scoreboard checked every cycle.
module tb_parking_gate_scheduler;

   localparam int CAP = 3;
   localparam int OC  = 4;
   localparam int CW  = $clog2(CAP + 1);

   logic          Clk = 1'b0;
   logic          Rst = 1'b0;
   logic          entReq = 1'b0, exitReq = 1'b0, entPass = 1'b0, exitPass = 1'b0;
   logic          entGrant, exitGrant, gateOpen, full, empty, timeoutErr;
   logic [CW-1:0] occupancy;

   parking_gate_scheduler #(.CAPACITY(CAP), .OPEN_CYCLES(OC)) dut (
      .Clk(Clk), .Rst(Rst),
      .entReq(entReq), .exitReq(exitReq), .entPass(entPass), .exitPass(exitPass),
      .entGrant(entGrant), .exitGrant(exitGrant), .gateOpen(gateOpen),
      .occupancy(occupancy), .full(full), .empty(empty), .timeoutErr(timeoutErr)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit eg; bit xg; bit go; int occ; bit fu; bit em; bit to;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: which lane holds the gate, for how long, cars inside
   int lane;      // 0 none, 1 entrance open, 2 exit open, 3 closed guard cycle
   int age;       // cycles the gate has been open so far
   int cars;
   int last_srv;  // 1 entrance, 2 exit
   bit tmo;
   bit entWait, exitWait;
   int rst_cnt;

   task automatic model_reset();
      lane = 0; age = 0; cars = 0; last_srv = 2; tmo = 0;
   endtask

   task automatic model_step(input bit eR, input bit xR, input bit eP, input bit xP);
      bit ent_ok, ex_ok;
      tmo = 0;
      if (lane == 0) begin
         ent_ok = eR && (cars < CAP);
         ex_ok  = xR && (cars > 0);
         if (ent_ok && ex_ok) begin
`ifdef PARK_EXIT_PRIORITY_EN
            lane = 2;
`else
            lane = (last_srv == 2) ? 1 : 2;
`endif
         end else if (ent_ok) lane = 1;
         else if (ex_ok)      lane = 2;
         if (lane != 0) begin age = 0; last_srv = lane; end
      end else if (lane == 3) begin
         lane = 0;
      end else begin
         age++;
         if (lane == 1 && eP) begin cars++; lane = 3; end
         else if (lane == 2 && xP) begin cars--; lane = 3; end
         else if (age == OC) begin tmo = 1; lane = 3; end
      end
   endtask

   function automatic exp_t expect_now();
      exp_t e;
      e.eg  = (lane == 1);
      e.xg  = (lane == 2);
      e.go  = (lane == 1) || (lane == 2);
      e.occ = cars;
      e.fu  = (cars == CAP);
      e.em  = (cars == 0);
      e.to  = tmo;
      return e;
   endfunction

   // Driver: advance the model for each edge, queue the expectation, drive next inputs
   initial begin
      model_reset();
      entWait = 0; exitWait = 0; rst_cnt = 0;
      repeat (3) begin
         @(posedge Clk); #1;
         q.push_back(expect_now());
      end
      Rst = 1'b1;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         @(posedge Clk); #1;
         if (Rst) model_step(entReq, exitReq, entPass, exitPass);
         if (rst_cnt > 0) begin
            rst_cnt--;
            if (rst_cnt == 0) Rst = 1'b1;
         end else if ($urandom_range(0, 249) == 0) begin
            Rst = 1'b0;
            rst_cnt = 2;
            model_reset();
            entWait = 0; exitWait = 0;
         end
         q.push_back(expect_now());
         if (lane == 1) entWait = 0;
         if (lane == 2) exitWait = 0;
         if (!entWait  && lane != 1 && $urandom_range(0, 5) == 0) entWait  = 1;
         if (!exitWait && lane != 2 && $urandom_range(0, 5) == 0) exitWait = 1;
         entReq   = entWait;
         exitReq  = exitWait;
         entPass  = (lane == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
         exitPass = (lane == 2) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
      end
      @(negedge Clk); #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Monitor: compare DUT outputs against queued expectations mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (entGrant !== e.eg || exitGrant !== e.xg || gateOpen !== e.go ||
                int'(occupancy) !== e.occ || full !== e.fu || empty !== e.em ||
                timeoutErr !== e.to) begin
               errors++;
               $display("FAIL outputs t=%0t got eg=%0b xg=%0b go=%0b occ=%0d full=%0b empty=%0b tmo=%0b required eg=%0b xg=%0b go=%0b occ=%0d full=%0b empty=%0b tmo=%0b",
                        $time, entGrant, exitGrant, gateOpen, occupancy, full, empty, timeoutErr,
                        e.eg, e.xg, e.go, e.occ, e.fu, e.em, e.to);
            end
         end
      end
   end

endmodule
